instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 4095, meaning the number of bytes in the target instruction memory.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the first byte address written after each start.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begins a load session.
REQ-006 SHALL have port in_valid, input, 1 bit: in_word and in_last are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-008 SHALL have port in_word, input, 32 bits: one instruction word.
REQ-009 SHALL have port in_last, input, 1 bit: this word is the final word of the session.
REQ-010 SHALL have port mem_we, output, 1 bit: byte write strobe to the memory.
REQ-011 SHALL have port mem_waddr, output, 64 bits: byte write address.
REQ-012 SHALL have port mem_wdata, output, 8 bits: write byte.
REQ-013 SHALL have port busy, output, 1 bit: high in ACCEPT or WRITE.
REQ-014 SHALL have port done, output, 1 bit: session completed without error.
REQ-015 SHALL have port overflow, output, 1 bit: session aborted because a word would exceed MEM_SIZE.
REQ-016 SHALL have port byte_count, output, 64 bits: bytes written this session.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCEPT, WRITE, DONE and ERROR.
REQ-018 IDLE, DONE or ERROR with start=1 SHALL go to ACCEPT next cycle, load the address register with BASE_ADDR, clear byte_count, and clear done and overflow.
REQ-019 start SHALL be ignored in ACCEPT and WRITE.
REQ-020 in_ready SHALL be 1 only in ACCEPT, decoded from state with no dependence on in_valid.
REQ-021 A handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1; it SHALL latch in_word and in_last.
REQ-022 On handshake, if addr+4 > MEM_SIZE, the FSM SHALL go to ERROR and perform no memory write; otherwise it SHALL go to WRITE with byte index 0.
REQ-023 WRITE SHALL last exactly 4 cycles, with mem_we=1, mem_waddr=addr+idx and mem_wdata = latched word bits [31-8*idx : 24-8*idx], for idx = 0..3.
REQ-024 The byte order SHALL be big-endian: the MSB goes to the lowest address, so the memory returns {mem[a], mem[a+1], mem[a+2], mem[a+3]} equal to the original word.
REQ-025 On the edge ending idx=3, addr and byte_count SHALL each increase by 4; the FSM SHALL then go to DONE if the latched last=1, else to ACCEPT.
REQ-026 Throughput SHALL be 5 cycles per word when in_valid is held at 1 (1 accept cycle plus 4 write cycles).
REQ-027 in_valid deasserted in ACCEPT SHALL hold the FSM in ACCEPT indefinitely with no writes.
REQ-028 mem_we SHALL be 0 in every state except WRITE.
REQ-029 mem_waddr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-030 done SHALL be 1 exactly while in DONE.
REQ-031 overflow SHALL be 1 exactly while in ERROR.
REQ-032 byte_count SHALL hold its value through DONE and ERROR.
REQ-033 Address arithmetic SHALL be 64-bit unsigned, and the overflow check SHALL not wrap.
REQ-034 A word ending exactly at MEM_SIZE (addr+4 == MEM_SIZE) SHALL be written normally.

Reset
REQ-035 reset=1 SHALL force, asynchronously and regardless of clk: state IDLE; in_ready, mem_we, busy, done and overflow to 0; mem_waddr to BASE_ADDR; mem_wdata to 0; byte_count to 0.
REQ-036 Reset asserted mid-WRITE SHALL deassert mem_we immediately.
REQ-037 A partially written word SHALL not be counted in byte_count.
REQ-038 After reset deasserts, the loader SHALL remain in IDLE until start=1.

Verification
REQ-039 Scenario single word: start, then word 0x00500093 with last=1 and MEM_SIZE=4095 -> writes 00,50,00,93 to addresses 0..3 on 4 consecutive cycles; then done=1 and byte_count=4.
REQ-040 Scenario back-to-back: 3 words with in_valid held at 1 -> handshakes 5 cycles apart; addresses 0..11; done=1 and byte_count=12 after the third word.
REQ-041 Scenario stall: in_valid=0 for 7 cycles in ACCEPT -> in_ready stays 1, mem_we stays 0, and addr is unchanged.
REQ-042 Scenario overflow: MEM_SIZE=10, 3 words -> 8 bytes written; third handshake gives overflow=1, no writes, byte_count=8.
REQ-043 Scenario reset mid-write: reset at idx=2 of word 2 -> mem_we=0 with no clock edge; byte_count=0 and the state is IDLE.
REQ-044 Scenario restart: start in DONE -> done clears, writes resume at BASE_ADDR, and start pulses during WRITE have no effect.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// big-endian, one byte per cycle, with a bounds check against MEM_SIZE.
module instr_mem_loader #(
    parameter logic [63:0] MEM_SIZE  = 64'd4095,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic        in_last,
    output logic        mem_we,
    output logic [63:0] mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [63:0] byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] addr;
    logic [31:0] word_q;
    logic        last_q;
    logic [1:0]  idx;
    logic [63:0] waddr_hold;
    logic [7:0]  wdata_hold;

    logic [64:0] end_addr;
    logic        fits;
    logic        idx_last;
    logic [63:0] cur_waddr;
    logic [7:0]  cur_byte;

    // One extra bit keeps the bounds check from wrapping near 2^64.
    assign end_addr  = {1'b0, addr} + 65'd4;
    assign fits      = (end_addr <= {1'b0, MEM_SIZE});
    assign idx_last  = (idx == 2'd3);
    assign cur_waddr = addr + {62'd0, idx};

    always_comb begin
        cur_byte = '0;
        case (idx)
            2'd0:    cur_byte = word_q[31:24];
            2'd1:    cur_byte = word_q[23:16];
            2'd2:    cur_byte = word_q[15:8];
            default: cur_byte = word_q[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                if (in_valid) begin
                    state_nxt = fits ? WRITE : ERROR;
                end
            end
            WRITE: begin
                if (idx_last) begin
                    state_nxt = last_q ? DONE : ACCEPT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCEPT);
        mem_we    = (state == WRITE);
        busy      = (state == ACCEPT) || (state == WRITE);
        done      = (state == DONE);
        overflow  = (state == ERROR);
        // Live address/data during WRITE, otherwise the last byte written.
        mem_waddr = (state == WRITE) ? cur_waddr : waddr_hold;
        mem_wdata = (state == WRITE) ? cur_byte  : wdata_hold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= BASE_ADDR;
            byte_count <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            idx        <= '0;
            waddr_hold <= BASE_ADDR;
            wdata_hold <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        addr       <= BASE_ADDR;
                        byte_count <= '0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        word_q <= in_word;
                        last_q <= in_last;
                        idx    <= '0;
                    end
                end
                WRITE: begin
                    waddr_hold <= cur_waddr;
                    wdata_hold <= cur_byte;
                    idx        <= idx + 2'd1;
                    if (idx_last) begin
                        addr       <= addr + 64'd4;
                        byte_count <= byte_count + 64'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Three loaders (default size, MEM_SIZE=10, MEM_SIZE=10 with BASE_ADDR=2) share one
// input stream; each is compared cycle by cycle against a behavioural model.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last;
    logic [31:0] in_word;

    logic        rdy_a, we_a, busy_a, done_a, ovf_a;
    logic        rdy_b, we_b, busy_b, done_b, ovf_b;
    logic        rdy_c, we_c, busy_c, done_c, ovf_c;
    logic [63:0] wa_a, wa_b, wa_c, cnt_a, cnt_b, cnt_c;
    logic [7:0]  wd_a, wd_b, wd_c;

    logic [2:0]        rdy_v, we_v, busy_v, done_v, ovf_v;
    logic [2:0][63:0]  wa_v, cnt_v;
    logic [2:0][7:0]   wd_v;

    localparam logic [63:0] MS [3] = '{64'd4095, 64'd10, 64'd10};
    localparam logic [63:0] BA [3] = '{64'd0, 64'd0, 64'd2};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_mem_loader #(.MEM_SIZE(64'd4095), .BASE_ADDR(64'd0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
        .in_word(in_word), .in_last(in_last), .mem_we(we_a), .mem_waddr(wa_a),
        .mem_wdata(wd_a), .busy(busy_a), .done(done_a), .overflow(ovf_a), .byte_count(cnt_a));

    instr_mem_loader #(.MEM_SIZE(64'd10), .BASE_ADDR(64'd0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
        .in_word(in_word), .in_last(in_last), .mem_we(we_b), .mem_waddr(wa_b),
        .mem_wdata(wd_b), .busy(busy_b), .done(done_b), .overflow(ovf_b), .byte_count(cnt_b));

    instr_mem_loader #(.MEM_SIZE(64'd10), .BASE_ADDR(64'd2)) dut_c (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_c),
        .in_word(in_word), .in_last(in_last), .mem_we(we_c), .mem_waddr(wa_c),
        .mem_wdata(wd_c), .busy(busy_c), .done(done_c), .overflow(ovf_c), .byte_count(cnt_c));

    assign rdy_v  = {rdy_c, rdy_b, rdy_a};
    assign we_v   = {we_c, we_b, we_a};
    assign busy_v = {busy_c, busy_b, busy_a};
    assign done_v = {done_c, done_b, done_a};
    assign ovf_v  = {ovf_c, ovf_b, ovf_a};
    assign wa_v   = {wa_c, wa_b, wa_a};
    assign cnt_v  = {cnt_c, cnt_b, cnt_a};
    assign wd_v   = {wd_c, wd_b, wd_a};

    // Reference model: accepting flag, bytes left to write, status flags, counters.
    bit          m_acc [3];
    int          m_left [3];
    bit          m_done [3];
    bit          m_ovf [3];
    bit          m_last [3];
    logic [63:0] m_addr [3];
    logic [63:0] m_cnt [3];
    logic [63:0] m_wa [3];
    logic [7:0]  m_wd [3];
    logic [31:0] m_word [3];

    logic [7:0]  bmem [3][4096];
    logic [31:0] words [$];

    task automatic check(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        logic [31:0] t;
        t = w >> (24 - 8 * k);
        return t[7:0];
    endfunction

    function automatic bit all_busy();
        for (int i = 0; i < 3; i++)
            if (!(m_acc[i] || m_left[i] > 0)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_left[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_last[i] = 0;
            m_addr[i] = BA[i]; m_cnt[i] = '0; m_wa[i] = BA[i]; m_wd[i] = '0; m_word[i] = '0;
        end
    endtask

    task automatic model_step();
        int k;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (m_left[i] > 0) begin
                k = 4 - m_left[i];
                m_wa[i] = m_addr[i] + 64'(k);
                m_wd[i] = byte_of(m_word[i], k);
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_addr[i] += 64'd4;
                    m_cnt[i]  += 64'd4;
                    if (m_last[i]) m_done[i] = 1; else m_acc[i] = 1;
                end
            end else if (m_acc[i]) begin
                if (in_valid) begin
                    m_acc[i] = 0;
                    if (m_addr[i] + 64'd4 > MS[i]) m_ovf[i] = 1;
                    else begin
                        m_left[i] = 4; m_word[i] = in_word; m_last[i] = in_last;
                    end
                end
            end else if (start) begin
                m_acc[i] = 1; m_done[i] = 0; m_ovf[i] = 0;
                m_addr[i] = BA[i]; m_cnt[i] = '0;
            end
        end
    endtask

    task automatic check_outputs();
        bit wr;
        for (int i = 0; i < 3; i++) begin
            wr = (m_left[i] > 0);
            check("in_ready", i, 64'(rdy_v[i]), 64'(m_acc[i]));
            check("mem_we", i, 64'(we_v[i]), 64'(wr));
            check("busy", i, 64'(busy_v[i]), 64'(m_acc[i] || wr));
            check("done", i, 64'(done_v[i]), 64'(m_done[i]));
            check("overflow", i, 64'(ovf_v[i]), 64'(m_ovf[i]));
            check("byte_count", i, cnt_v[i], m_cnt[i]);
            check("mem_waddr", i, wa_v[i], wr ? m_addr[i] + 64'(4 - m_left[i]) : m_wa[i]);
            check("mem_wdata", i, 64'(wd_v[i]), 64'(wr ? byte_of(m_word[i], 4 - m_left[i]) : m_wd[i]));
            if (we_v[i] === 1'b1) bmem[i][wa_v[i][11:0]] = wd_v[i];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run_session(input int stall_pct, input int init_stall, input bit pulses, input int abort_w);
        int  n, w, cyc, budget, nw;
        bit  consumed, aborted;
        logic [63:0] a;
        logic [31:0] got;
        n = words.size(); w = 0; cyc = 0; aborted = 0;
        budget = 10 * n + 50;
        start = 1; in_valid = 0;
        tick();
        start = 0;
        while (cyc < budget) begin
            if (!(m_acc[0] || m_left[0] > 0)) break;
            in_valid = (w < n) && (cyc >= init_stall) && ($urandom_range(99) >= stall_pct);
            in_word  = (w < n) ? words[w] : $urandom;
            in_last  = (w == n - 1);
            start    = pulses && all_busy() && ($urandom_range(3) == 0);
            consumed = m_acc[0] && in_valid;
            tick();
            start = 0;
            if (consumed) w++;
            cyc++;
            if (abort_w >= 0 && w == abort_w && m_left[0] == 2) begin
                #2 reset = 1;
                #1 model_reset();
                check_outputs();
                aborted = 1;
                break;
            end
        end
        check("session_timeout", 0, 64'(cyc >= budget), 64'd0);
        in_valid = 0;
        if (!aborted) begin
            for (int i = 0; i < 3; i++) begin
                nw = int'(m_cnt[i] / 64'd4);
                for (int k = 0; k < nw; k++) begin
                    a   = BA[i] + 64'(4 * k);
                    got = {bmem[i][a[11:0]], bmem[i][a[11:0] + 12'd1],
                           bmem[i][a[11:0] + 12'd2], bmem[i][a[11:0] + 12'd3]};
                    check("word_readback", i, 64'(got), 64'(words[k]));
                end
            end
        end
    endtask

    initial begin
        reset = 0; start = 0; in_valid = 0; in_word = '0; in_last = 0;
        #1 reset = 1;
        #1 model_reset();
        check_outputs();
        repeat (2) tick();
        reset = 0;
        repeat (4) begin
            in_valid = 1'($urandom);
            in_word  = $urandom;
            tick();
        end
        in_valid = 0;

        // Single word, big-endian byte order.
        words = '{32'h00500093};
        run_session(0, 0, 0, -1);
        check("sw_b0", 0, 64'(bmem[0][0]), 64'h00);
        check("sw_b1", 0, 64'(bmem[0][1]), 64'h50);
        check("sw_b2", 0, 64'(bmem[0][2]), 64'h00);
        check("sw_b3", 0, 64'(bmem[0][3]), 64'h93);
        check("sw_count", 0, cnt_a, 64'd4);
        check("sw_done", 0, 64'(done_a), 64'd1);

        // Back-to-back: b overflows on word 3, c fills exactly to MEM_SIZE then overflows.
        words = '{$urandom, $urandom, $urandom};
        run_session(0, 0, 0, -1);
        check("b2b_count", 0, cnt_a, 64'd12);
        check("b2b_done", 0, 64'(done_a), 64'd1);
        check("ovf_count", 1, cnt_b, 64'd8);
        check("ovf_flag", 1, 64'(ovf_b), 64'd1);
        check("edge_count", 2, cnt_c, 64'd8);
        check("edge_flag", 2, 64'(ovf_c), 64'd1);

        // Stall in ACCEPT for 7 cycles, then random gaps.
        words = '{$urandom, $urandom, $urandom, $urandom};
        run_session(30, 7, 0, -1);

        // Restart from DONE with start pulses while busy.
        words = '{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_session(25, 0, 1, -1);
        check("restart_done", 0, 64'(done_a), 64'd1);

        // Reset during byte index 2 of the second word.
        words = '{$urandom, $urandom, $urandom};
        run_session(0, 0, 0, 2);
        check("rst_count", 0, cnt_a, 64'd0);
        check("rst_we", 0, 64'(we_a), 64'd0);
        repeat (2) tick();
        reset = 0;
        repeat (5) begin
            in_valid = 1'($urandom);
            tick();
        end
        in_valid = 0;

        repeat (6) begin
            words = {};
            repeat ($urandom_range(8, 1)) words.push_back($urandom);
            run_session($urandom_range(50), $urandom_range(3), 1'($urandom), -1);
        end

        // Fill the default-size memory until the word at 4092 no longer fits.
        words = {};
        repeat (1024) words.push_back($urandom);
        run_session(10, 0, 0, -1);
        check("full_count", 0, cnt_a, 64'd4092);
        check("full_ovf", 0, 64'(ovf_a), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
